// File: rtl/ram_dma.sv
// ram_dma: single-channel byte DMA engine for a synchronous RAM.
//
// Copies len bytes from src_addr to dst_addr (mode=0), or fills len bytes at
// dst_addr with fill_value (mode=1). Addresses wrap modulo 2**ram_width.
//
// Optional feature: define RAM_DMA_CHECKSUM_EN to add the checksum output,
// the 8-bit wrapping sum of every byte written by the current transfer.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           transfer request, only honoured in IDLE
//   mode            0 = copy, 1 = fill
//   src_addr        copy source base address
//   dst_addr        destination base address
//   len             byte count, 0 .. 2**ram_width
//   fill_value      fill byte
//   ram_data_read   RAM read data, valid the cycle after ram_re
//   busy            transfer in progress
//   done            one-cycle completion pulse
//   ram_re, ram_we  RAM read / write enables (never both high)
//   ram_addr        RAM address
//   ram_data_write  RAM write data
//   checksum        sum of written bytes (RAM_DMA_CHECKSUM_EN only)
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; outputs idle, address/data hold
// RD     | ram_re high at the current source address
// WR     | ram_we high at the current destination, data from the RAM read
// FILL   | ram_we high at the current destination with the fill byte
// FIN    | done pulse, busy low; back to IDLE next cycle

module ram_dma #(
    parameter int ram_width = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ram_width-1:0] src_addr,
    input  logic [ram_width-1:0] dst_addr,
    input  logic [ram_width:0]   len,
    input  logic [7:0]           fill_value,
    input  logic [7:0]           ram_data_read,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_re,
    output logic                 ram_we,
    output logic [ram_width-1:0] ram_addr,
    output logic [7:0]           ram_data_write
`ifdef RAM_DMA_CHECKSUM_EN
    ,
    output logic [7:0]           checksum
`endif
);

    localparam logic [ram_width-1:0] ADDR_ONE = {{(ram_width-1){1'b0}}, 1'b1};
    localparam logic [ram_width:0]   CNT_ONE  = {{ram_width{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FILL = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t               state;
    logic [ram_width-1:0] src_ptr;
    logic [ram_width-1:0] dst_ptr;
    logic [ram_width:0]   remaining;
    logic [7:0]           wdata_q;
    logic                 wr_pass;

    // The read byte only arrives in the write cycle itself, so during WR the
    // write data is forwarded straight from the RAM; wdata_q captures it so the
    // bus keeps its last value afterwards. Every other cycle drives the register.
    assign ram_data_write = wr_pass ? ram_data_read : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            wdata_q   <= '0;
            wr_pass   <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        remaining <= len;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state    <= FILL;
                            busy     <= 1'b1;
                            ram_we   <= 1'b1;
                            ram_addr <= dst_addr;
                            dst_ptr  <= dst_addr + ADDR_ONE;
                            wdata_q  <= fill_value;
                        end else begin
                            state    <= RD;
                            busy     <= 1'b1;
                            ram_re   <= 1'b1;
                            ram_addr <= src_addr;
                            src_ptr  <= src_addr + ADDR_ONE;
                            dst_ptr  <= dst_addr;
                        end
                    end
                end

                RD: begin
                    state    <= WR;
                    ram_re   <= 1'b0;
                    ram_we   <= 1'b1;
                    wr_pass  <= 1'b1;
                    ram_addr <= dst_ptr;
                    dst_ptr  <= dst_ptr + ADDR_ONE;
                end

                WR: begin
                    wdata_q   <= ram_data_read;
                    wr_pass   <= 1'b0;
                    ram_we    <= 1'b0;
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= RD;
                        ram_re   <= 1'b1;
                        ram_addr <= src_ptr;
                        src_ptr  <= src_ptr + ADDR_ONE;
                    end
                end

                FILL: begin
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state  <= FIN;
                        ram_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        ram_addr <= dst_ptr;
                        dst_ptr  <= dst_ptr + ADDR_ONE;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    ram_re <= 1'b0;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_DMA_CHECKSUM_EN
    // Cleared only by an accepted start, so the value survives done and FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (ram_we) begin
            checksum <= checksum + ram_data_write;
        end
    end
`endif

endmodule
